// File: rtl/decimal_to_binary32.sv
// decimal_to_binary32
//   Sequential BCD-to-binary converter (reverse double dabble, one bit per clock).
//   Ten packed BCD digits in, 32-bit unsigned binary out, saturating on overflow.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start        request a conversion (sampled only while idle)
//   bcd_in[39:0] ten BCD digits, [39:36] = billions ... [3:0] = ones
//   busy         high while a conversion is in progress
//   done         one-cycle pulse when results update
//   binary_out   converted value, held between conversions
//   overflow     value exceeded 32 bits; binary_out saturated to all ones
//   digit_error  at least one captured digit was > 9
module decimal_to_binary32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [39:0] bcd_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] binary_out,
    output logic        overflow,
    output logic        digit_error
);

    typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;

    state_t      state_q, state_d;
    logic [39:0] bcd_q, bcd_d;
    logic [33:0] acc_q, acc_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        busy_d, done_d, ovf_d, derr_d;
    logic [31:0] bin_d;

    logic        in_bad;
    logic [73:0] shifted;
    logic [39:0] bcd_adj;

    // Any incoming nibble above 9 selects the error path at capture.
    always_comb begin
        in_bad = 1'b0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) in_bad = 1'b1;
        end
    end

    // One reverse-dabble step: shift right, then correct nibbles that are >= 8
    // (top bit set) by subtracting 3.
    always_comb begin
        shifted = {bcd_q, acc_q} >> 1;
        bcd_adj = shifted[73:34];
        for (int unsigned i = 0; i < 10; i++) begin
            if (shifted[34 + 4*i + 3]) bcd_adj[4*i +: 4] = shifted[34 + 4*i +: 4] - 4'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        busy_d  = busy;
        done_d  = 1'b0;
        bin_d   = binary_out;
        ovf_d   = overflow;
        derr_d  = digit_error;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bcd_d   = bcd_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = in_bad;
                    busy_d  = 1'b1;
                    state_d = in_bad ? FINISH : CONV;
                end
            end
            CONV: begin
                bcd_d = bcd_adj;
                acc_d = shifted[33:0];
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd33) state_d = FINISH;
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (err_q) begin
                    bin_d  = '0;
                    ovf_d  = 1'b0;
                    derr_d = 1'b1;
                end else if (acc_q[33:32] != 2'b00) begin
                    bin_d  = '1;
                    ovf_d  = 1'b1;
                    derr_d = 1'b0;
                end else begin
                    bin_d  = acc_q[31:0];
                    ovf_d  = 1'b0;
                    derr_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bcd_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            binary_out  <= '0;
            overflow    <= 1'b0;
            digit_error <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcd_q       <= bcd_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            busy        <= busy_d;
            done        <= done_d;
            binary_out  <= bin_d;
            overflow    <= ovf_d;
            digit_error <= derr_d;
        end
    end

endmodule
